// File: rtl/sad_matcher.sv
// 16x16 SAD template matcher: 3-stage pipeline plus a min-SAD tracker over one frame of windows.
// Optional macro SAD_THRESHOLD_EN adds sad_thresh input and match_found output.
module sad_matcher #(
  parameter int XMAX = 64,
  parameter int YMAX = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   template_load,
  input  logic [15:0][15:0][7:0] template_data,
  input  logic [15:0][15:0][7:0] window_data,
  input  logic                   window_ready,
  input  logic                   frame_done,
`ifdef SAD_THRESHOLD_EN
  input  logic [15:0]            sad_thresh,
  output logic                   match_found,
`endif
  output logic                   receive,
  output logic                   busy,
  output logic                   match_valid,
  output logic [15:0]            best_sad,
  output logic [6:0]             best_x,
  output logic [6:0]             best_y
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, REPORT} state_t;

  localparam logic [6:0] X_LAST = 7'(XMAX);
  localparam logic [6:0] Y_LAST = 7'(YMAX);

  state_t                 state_q, state_d;
  logic [1:0]             drain_cnt_q, drain_cnt_d;
  logic [6:0]             x_q, x_d, y_q, y_d;
  logic                   sat_q, sat_d;
  logic [15:0][15:0][7:0] template_q;

  logic [15:0][15:0][7:0] absd_d, absd_q;
  logic [15:0][11:0]      row_d, row_q;
  logic [15:0]            sad_d, sad_q;
  logic                   s1_vld_q, s2_vld_q, s3_vld_q;
  logic [6:0]             s1_x_q, s1_y_q, s2_x_q, s2_y_q, s3_x_q, s3_y_q;

  logic [15:0]            best_sad_q;
  logic [6:0]             best_x_q, best_y_q;

  // ---------------- control FSM ----------------
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      IDLE:   state_d = IDLE;
      RUN: begin
        if (frame_done) begin
          state_d     = DRAIN;
          drain_cnt_d = 2'd0;
        end
      end
      DRAIN: begin
        if (drain_cnt_q == 2'd2) state_d = REPORT;
        else                     drain_cnt_d = drain_cnt_q + 2'd1;
      end
      REPORT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (start) state_d = RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      drain_cnt_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  assign receive     = window_ready && (state_q == RUN) && !sat_q;
  assign busy        = (state_q != IDLE);
  assign match_valid = (state_q == REPORT);

  // ---------------- window position counter ----------------
  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    sat_d = sat_q;
    if (start) begin
      x_d   = 7'd0;
      y_d   = 7'd0;
      sat_d = 1'b0;
    end else if (receive) begin
      if (x_q == X_LAST) begin
        // Tag (XMAX, YMAX) was the last one; stop accepting until the next start.
        if (y_q == Y_LAST) begin
          sat_d = 1'b1;
        end else begin
          x_d = 7'd0;
          y_d = y_q + 7'd1;
        end
      end else begin
        x_d = x_q + 7'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= 7'd0;
      y_q   <= 7'd0;
      sat_q <= 1'b0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      sat_q <= sat_d;
    end
  end

  // ---------------- template register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 template_q <= '0;
    else if (template_load && state_q == IDLE)  template_q <= template_data;
  end

  // ---------------- SAD pipeline ----------------
  for (genvar gi = 0; gi < 16; gi++) begin : g_row
    for (genvar gj = 0; gj < 16; gj++) begin : g_col
      assign absd_d[gi][gj] = (window_data[gi][gj] > template_q[gi][gj])
                            ? (window_data[gi][gj] - template_q[gi][gj])
                            : (template_q[gi][gj] - window_data[gi][gj]);
    end
  end

  always_comb begin
    for (int r = 0; r < 16; r++) begin
      row_d[r] = 12'd0;
      for (int c = 0; c < 16; c++) row_d[r] = row_d[r] + 12'(absd_q[r][c]);
    end
  end

  always_comb begin
    sad_d = 16'd0;
    for (int r = 0; r < 16; r++) sad_d = sad_d + 16'(row_q[r]);
  end

  // Datapath registers need no reset; the valid bits below qualify them.
  always_ff @(posedge clk) begin
    absd_q <= absd_d;
    s1_x_q <= x_q;
    s1_y_q <= y_q;
    row_q  <= row_d;
    s2_x_q <= s1_x_q;
    s2_y_q <= s1_y_q;
    sad_q  <= sad_d;
    s3_x_q <= s2_x_q;
    s3_y_q <= s2_y_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s3_vld_q <= 1'b0;
    end else if (start) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s3_vld_q <= 1'b0;
    end else begin
      s1_vld_q <= receive;
      s2_vld_q <= s1_vld_q;
      s3_vld_q <= s2_vld_q;
    end
  end

  // ---------------- best-match tracker ----------------
  // Strict less-than keeps the earliest window on a tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_sad_q <= 16'hFFFF;
      best_x_q   <= 7'd0;
      best_y_q   <= 7'd0;
    end else if (start) begin
      best_sad_q <= 16'hFFFF;
      best_x_q   <= 7'd0;
      best_y_q   <= 7'd0;
    end else if (s3_vld_q && (sad_q < best_sad_q)) begin
      best_sad_q <= sad_q;
      best_x_q   <= s3_x_q;
      best_y_q   <= s3_y_q;
    end
  end

  assign best_sad = best_sad_q;
  assign best_x   = best_x_q;
  assign best_y   = best_y_q;

`ifdef SAD_THRESHOLD_EN
  assign match_found = (state_q == REPORT) && (best_sad_q <= sad_thresh);
`endif

endmodule

// File: tb/tb_sad_matcher.sv
// Directed self-checking bench for sad_matcher: full 65x65 frames plus short control scenarios.
`timescale 1ns/1ps
module tb_sad_matcher;

  typedef logic [15:0][15:0][7:0] blk_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, template_load, window_ready, frame_done;
  blk_t        template_data, window_data;
  logic        receive, busy, match_valid;
  logic [15:0] best_sad;
  logic [6:0]  best_x, best_y;
`ifdef SAD_THRESHOLD_EN
  logic [15:0] sad_thresh;
  logic        match_found;
`endif

  int   n_cmp = 0;
  int   n_bad = 0;
  blk_t tpl;
  blk_t zero_blk;

  always #5 clk = ~clk;

  sad_matcher dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .template_load(template_load),
    .template_data(template_data),
    .window_data  (window_data),
    .window_ready (window_ready),
    .frame_done   (frame_done),
`ifdef SAD_THRESHOLD_EN
    .sad_thresh   (sad_thresh),
    .match_found  (match_found),
`endif
    .receive      (receive),
    .busy         (busy),
    .match_valid  (match_valid),
    .best_sad     (best_sad),
    .best_x       (best_x),
    .best_y       (best_y)
  );

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

  // First n pixels (raster order) get +d over the template, so SAD = n*d.
  function automatic blk_t mkdelta(input int n, input int d);
    blk_t w;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        w[r][c] = tpl[r][c] + (((r * 16 + c) < n) ? 8'(d) : 8'd0);
    return w;
  endfunction

  function automatic blk_t mkwin(input int kind, input int x, input int y);
    blk_t w;
    case (kind)
      0:       w = (x == 17 && y == 40) ? mkdelta(0, 0) : mkdelta(256, 1);
      1:       w = ((x == 3 && y == 0) || (x == 10 && y == 5)) ? mkdelta(100, 1) : mkdelta(256, 1);
      2:       w = {256{8'hFF}};
      3:       w = (x == 64 && y == 64) ? mkdelta(0, 0) : mkdelta(256, 1);
      default: w = mkdelta(256, 1);
    endcase
    return w;
  endfunction

  task automatic drive_idle();
    window_ready  = 1'b0;
    frame_done    = 1'b0;
    start         = 1'b0;
    template_load = 1'b0;
  endtask

  task automatic send_win(input blk_t w, input bit fd, output bit rx);
    @(negedge clk);
    drive_idle();
    window_data  = w;
    window_ready = 1'b1;
    frame_done   = fd;
    #1 rx = receive;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    drive_idle();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load_tpl(input blk_t t);
    @(negedge clk);
    drive_idle();
    template_data = t;
    template_load = 1'b1;
    @(negedge clk);
    template_load = 1'b0;
  endtask

  task automatic send_frame(input int kind, input bit fd_last, output int rx_bad);
    bit rx;
    rx_bad = 0;
    for (int y = 0; y <= 64; y++)
      for (int x = 0; x <= 64; x++) begin
        send_win(mkwin(kind, x, y), fd_last && (x == 64) && (y == 64), rx);
        if (rx !== 1'b1) rx_bad++;
      end
  endtask

  // Returns the number of cycles from the frame_done cycle to match_valid, -1 if none within 20.
  task automatic wait_report(output int lat);
    int i;
    lat = -1;
    i = 0;
    while (lat < 0 && i < 20) begin
      i++;
      @(negedge clk);
      drive_idle();
      if (match_valid === 1'b1) lat = i;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    template_data = '0;
    window_data   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    window_ready = 1'b1;
    #1;
    n_cmp++; if (receive !== 1'b0) begin n_bad++; $display("FAIL reset_receive: got %b expected 0", receive); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (match_valid !== 1'b0) begin n_bad++; $display("FAIL reset_match_valid: got %b expected 0", match_valid); end
    n_cmp++; if ({best_sad, best_x, best_y} !== {16'hFFFF, 7'd0, 7'd0}) begin
      n_bad++; $display("FAIL reset_best: got sad=%0d x=%0d y=%0d expected sad=65535 x=0 y=0", best_sad, best_x, best_y);
    end
    $display("reset: outputs sad=%0d x=%0d y=%0d busy=%b", best_sad, best_x, best_y, busy);
    window_ready = 1'b0;
  endtask

  task automatic test_identical();
    int rxb, lat;
    load_tpl(tpl);
    pulse_start();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ident_busy_run: got %b expected 1", busy); end
    send_frame(0, 1'b1, rxb);
    n_cmp++; if (rxb !== 0) begin n_bad++; $display("FAIL ident_receive: got %0d rejected windows expected 0", rxb); end
    wait_report(lat);
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL ident_latency: got %0d expected 4", lat); end
    n_cmp++; if ({best_sad, best_x, best_y} !== {16'd0, 7'd17, 7'd40}) begin
      n_bad++; $display("FAIL ident_best: got sad=%0d x=%0d y=%0d expected sad=0 x=17 y=40", best_sad, best_x, best_y);
    end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ident_busy_report: got %b expected 1", busy); end
    $display("identical: lat=%0d sad=%0d x=%0d y=%0d", lat, best_sad, best_x, best_y);
    @(negedge clk);
    n_cmp++; if ({busy, match_valid} !== 2'b00) begin
      n_bad++; $display("FAIL ident_after_report: got busy=%b mv=%b expected 0 0", busy, match_valid);
    end
    n_cmp++; if (best_sad !== 16'd0) begin n_bad++; $display("FAIL ident_hold: got %0d expected 0", best_sad); end
  endtask

  task automatic test_tie();
    int rxb, lat;
    pulse_start();
    send_frame(1, 1'b1, rxb);
    wait_report(lat);
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL tie_latency: got %0d expected 4", lat); end
    n_cmp++; if ({best_sad, best_x, best_y} !== {16'd100, 7'd3, 7'd0}) begin
      n_bad++; $display("FAIL tie_best: got sad=%0d x=%0d y=%0d expected sad=100 x=3 y=0", best_sad, best_x, best_y);
    end
    $display("tie: lat=%0d sad=%0d x=%0d y=%0d", lat, best_sad, best_x, best_y);
    @(negedge clk);
  endtask

  task automatic test_worst();
    int rxb, lat;
    load_tpl(zero_blk);
    pulse_start();
    send_frame(2, 1'b1, rxb);
    wait_report(lat);
    n_cmp++; if ({best_sad, best_x, best_y} !== {16'd65280, 7'd0, 7'd0}) begin
      n_bad++; $display("FAIL worst_best: got sad=%0d x=%0d y=%0d expected sad=65280 x=0 y=0", best_sad, best_x, best_y);
    end
    $display("worst: lat=%0d sad=%0d x=%0d y=%0d", lat, best_sad, best_x, best_y);
    @(negedge clk);
    load_tpl(tpl);
  endtask

  task automatic test_back_to_back();
    int rxb, lat;
    bit rx;
    pulse_start();
    send_frame(3, 1'b1, rxb);
    wait_report(lat);
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL b2b_latency: got %0d expected 4", lat); end
    n_cmp++; if ({best_sad, best_x, best_y} !== {16'd0, 7'd64, 7'd64}) begin
      n_bad++; $display("FAIL b2b_last_best: got sad=%0d x=%0d y=%0d expected sad=0 x=64 y=64", best_sad, best_x, best_y);
    end
    $display("b2b last window: lat=%0d sad=%0d x=%0d y=%0d", lat, best_sad, best_x, best_y);
    @(negedge clk);
    // Saturation: 4225 windows of SAD 256, then a perfect 4226th that must be dropped.
    pulse_start();
    send_frame(4, 1'b0, rxb);
    send_win(mkdelta(0, 0), 1'b0, rx);
    n_cmp++; if (rx !== 1'b0) begin n_bad++; $display("FAIL sat_receive: got %b expected 0", rx); end
    @(negedge clk);
    drive_idle();
    frame_done = 1'b1;
    wait_report(lat);
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL sat_latency: got %0d expected 4", lat); end
    n_cmp++; if ({best_sad, best_x, best_y} !== {16'd256, 7'd0, 7'd0}) begin
      n_bad++; $display("FAIL sat_best: got sad=%0d x=%0d y=%0d expected sad=256 x=0 y=0", best_sad, best_x, best_y);
    end
    $display("saturation: rx4226=%b sad=%0d x=%0d y=%0d", rx, best_sad, best_x, best_y);
    @(negedge clk);
  endtask

  task automatic test_control();
    int lat, seen;
    bit rx;
    // template_load while running must not replace the template
    pulse_start();
    load_tpl(zero_blk);
    send_win(mkdelta(0, 0), 1'b1, rx);
    wait_report(lat);
    n_cmp++; if ({best_sad, best_x, best_y} !== {16'd0, 7'd0, 7'd0}) begin
      n_bad++; $display("FAIL ctl_tpl_locked: got sad=%0d x=%0d y=%0d expected sad=0 x=0 y=0", best_sad, best_x, best_y);
    end
    $display("control tpl-load in RUN: sad=%0d", best_sad);
    @(negedge clk);
    // start right behind a perfect window flushes it from the pipeline
    pulse_start();
    send_win(mkdelta(0, 0), 1'b0, rx);
    pulse_start();
    send_win(mkdelta(256, 2), 1'b0, rx);
    send_win(mkdelta(256, 1), 1'b1, rx);
    wait_report(lat);
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL ctl_restart_latency: got %0d expected 4", lat); end
    n_cmp++; if ({best_sad, best_x, best_y} !== {16'd256, 7'd1, 7'd0}) begin
      n_bad++; $display("FAIL ctl_restart_best: got sad=%0d x=%0d y=%0d expected sad=256 x=1 y=0", best_sad, best_x, best_y);
    end
    $display("control restart: sad=%0d x=%0d y=%0d", best_sad, best_x, best_y);
    @(negedge clk);
    // asynchronous reset in the middle of a frame
    pulse_start();
    send_win(mkdelta(0, 0), 1'b0, rx);
    send_win(mkdelta(0, 0), 1'b0, rx);
    @(negedge clk);
    drive_idle();
    window_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({receive, busy, match_valid, best_sad, best_x, best_y} !== {3'b000, 16'hFFFF, 7'd0, 7'd0}) begin
      n_bad++; $display("FAIL ctl_reset_outputs: got rx=%b busy=%b mv=%b sad=%0d x=%0d y=%0d expected 0 0 0 65535 0 0",
                        receive, busy, match_valid, best_sad, best_x, best_y);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive_idle();
    frame_done = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive_idle();
      if (match_valid === 1'b1) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL ctl_reset_no_report: got %0d match_valid cycles expected 0", seen); end
    n_cmp++; if ({busy, best_sad} !== {1'b0, 16'hFFFF}) begin
      n_bad++; $display("FAIL ctl_reset_idle: got busy=%b sad=%0d expected 0 65535", busy, best_sad);
    end
    $display("control mid-frame reset: mv_cycles=%0d sad=%0d", seen, best_sad);
    load_tpl(tpl);
  endtask

`ifdef SAD_THRESHOLD_EN
  task automatic test_threshold();
    int lat;
    bit rx;
    sad_thresh = 16'd50;
    pulse_start();
    send_win(mkdelta(50, 1), 1'b1, rx);
    wait_report(lat);
    n_cmp++; if ({best_sad, match_found} !== {16'd50, 1'b1}) begin
      n_bad++; $display("FAIL thresh_equal: got sad=%0d found=%b expected sad=50 found=1", best_sad, match_found);
    end
    $display("threshold 50 vs sad 50: found=%b", match_found);
    @(negedge clk);
    pulse_start();
    send_win(mkdelta(51, 1), 1'b1, rx);
    wait_report(lat);
    n_cmp++; if ({best_sad, match_found} !== {16'd51, 1'b0}) begin
      n_bad++; $display("FAIL thresh_above: got sad=%0d found=%b expected sad=51 found=0", best_sad, match_found);
    end
    $display("threshold 50 vs sad 51: found=%b", match_found);
    @(negedge clk);
  endtask
`endif

  initial begin
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        tpl[r][c] = 8'((r * 16 + c) % 200);
    zero_blk = '0;
`ifdef SAD_THRESHOLD_EN
    sad_thresh = 16'd0;
`endif
    test_reset();
    test_identical();
    test_tie();
    test_worst();
    test_back_to_back();
    test_control();
`ifdef SAD_THRESHOLD_EN
    test_threshold();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sad_matcher.md
# sad_matcher

Template-matching stage directly downstream of the window handler. It accepts one 16x16 byte window per cycle on the handler's `window_ready` strobe and computes the sum of absolute differences (SAD) against a stored 16x16 template in a 3-stage pipeline. It tracks the minimum SAD and its window coordinate across an 80x80 frame (65x65 window positions) and reports the best match once the frame completes.

## Interface
Parameters:
- `XMAX`, default 64: last window x index per row; x wraps to 0 after this value.
- `YMAX`, default 64: last window y index per frame.

Ports:
- `clk`, input, 1: clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: pulse; clears the trackers and enters RUN. Honoured in every state.
- `template_load`, input, 1: pulse; captures `template_data`. Honoured only in IDLE.
- `template_data`, input, [15:0][15:0][7:0]: template pixels.
- `window_data`, input, [15:0][15:0][7:0]: window from the handler.
- `window_ready`, input, 1: `window_data` is valid this cycle.
- `frame_done`, input, 1: the handler's `done` pulse.
- `receive`, output, 1: window accepted this cycle. Combinational: `window_ready` && state==RUN && not saturated.
- `busy`, output, 1: high in RUN, DRAIN and REPORT.
- `match_valid`, output, 1: one-cycle pulse in REPORT.
- `best_sad`, output, 16: minimum SAD. Holds its value after REPORT.
- `best_x`, output, 7: window x of the minimum. Holds its value after REPORT.
- `best_y`, output, 7: window y of the minimum. Holds its value after REPORT.

## Operation
- **Template register:** 2048 bits. Reset value is 0. Loads on `template_load` in IDLE and is ignored in all other states.
- **Pipeline**, advanced only by accepted windows. Each stage carries a valid bit and the (x, y) tag.
  - S1: 256 absolute differences, 8 bits each.
  - S2: 16 row sums, 12 bits each.
  - S3: total SAD, 16 bits. The maximum is 256*255 = 65280, so there is no overflow.
- **Tracker:** when an S3 result is valid and SAD < `best_sad`, update `best_sad`, `best_x` and `best_y`. The comparison is strict, so on a tie the earliest window wins.
- **Position counter** (x, y), cleared by `start`:
  - Each accepted window takes the current (x, y) as its tag.
  - Then x increments; at x==XMAX, x returns to 0 and y increments.
  - After tag (XMAX, YMAX) the counter saturates. Further windows are not accepted (`receive`=0) and are ignored.
- **FSM states:**
  - IDLE: `start` goes to RUN.
  - RUN: `frame_done` goes to DRAIN; `start` restarts RUN.
  - DRAIN: lasts 3 cycles so that S1–S3 empty, then goes to REPORT.
  - REPORT: 1 cycle, asserts `match_valid`, then goes to IDLE.
- **`start` effects:** sets `best_sad` to 16'hFFFF, sets `best_x`/`best_y` to 0, sets (x, y) to 0, flushes the pipeline valid bits and enters RUN. This applies in any state.
- **Frame end:** a window with `window_ready` in the same cycle as `frame_done` in RUN is accepted and included in the result. `window_ready` in IDLE, DRAIN or REPORT is ignored.
- **No windows:** if no window is accepted in a frame, REPORT shows `best_sad`=FFFF and (0, 0).

## Timing
- **Reset values:** state IDLE, `receive`=0, `busy`=0, `match_valid`=0, `best_sad`=FFFF, `best_x`=0, `best_y`=0. All pipeline valid bits are 0.
- **Latency:** a window accepted at cycle t has its SAD compared at the edge ending cycle t+3. The tracker outputs reflect it from cycle t+4.
- **Throughput:** one window per cycle, with no backpressure. The handler may assert `window_ready` on consecutive cycles.
- **End of frame:** with `frame_done` at cycle t, DRAIN covers t+1..t+3, `match_valid` is high at t+4 and `busy` falls at t+5.
- **Reset mid-frame:** reset asserted mid-frame returns immediately to the reset values, and no `match_valid` is emitted.

## Configuration
- **Macro `SAD_THRESHOLD_EN`.**
- **Defined:** adds the input `sad_thresh` [15:0], sampled in REPORT, and the output `match_found`.
  - `match_found` is high in the REPORT cycle iff `best_sad` <= `sad_thresh`.
  - Otherwise `match_found` is 0; its reset value is 0.
- **Undefined:** neither port exists, and behaviour is otherwise identical.

## Test plan
- **Identical template:** load a template, send a full 65x65 frame in which only window (17, 40) equals the template and all others differ by 1 per pixel. Require `match_valid` at `frame_done`+4 with `best_sad`=0, `best_x`=17, `best_y`=40.
- **Tie:** windows (3, 0) and (10, 5) both give SAD 100 and all others give more. Require `best_x`=3, `best_y`=0.
- **Worst case:** template all 00 and windows all FF. Require `best_sad`=65280.
- **Back-to-back with final window:** windows on consecutive cycles, with the last window coincident with `frame_done`, where that last window is the minimum (tag 64, 64). Require that it is reported. A 4226th window gives `receive`=0 and is ignored.
- **Control during operation:** `template_load` during RUN leaves the template unchanged. `start` mid-frame clears the best value, and the previously best window is not reported. `rst_n` low mid-frame gives all outputs at their reset values and no `match_valid`.
- **`SAD_THRESHOLD_EN`:** with `sad_thresh`=50, `best_sad`=50 gives `match_found`=1 and `best_sad`=51 gives `match_found`=0.
